// File: rtl/axi_resp_stall_injector.sv
// AXI4 pass-through that injects programmable stall bubbles on the B and R response channels.
// Define AXI_RESP_STALL_INJ_STATS_EN to add saturating stall-cycle counters on two extra outputs.

package axi_resp_stall_injector_pkg;
  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
  } ax_chan_t;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  strb;
    logic        last;
  } w_chan_t;

  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
  } b_chan_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
  } r_chan_t;

  typedef struct packed {
    ax_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ax_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } axi_req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    logic    b_valid;
    b_chan_t b;
    logic    r_valid;
    r_chan_t r;
  } axi_resp_t;
endpackage

module axi_resp_stall_injector #(
  parameter type req_t  = axi_resp_stall_injector_pkg::axi_req_t,
  parameter type resp_t = axi_resp_stall_injector_pkg::axi_resp_t,
  parameter int unsigned StallWidth = 8,
  parameter logic [StallWidth-1:0] InitialBStall = '0,
  parameter logic [StallWidth-1:0] InitialRStall = '0,
  parameter logic [15:0] LfsrSeed = 16'hACE1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cfg_en_i,
  input  logic [StallWidth-1:0] cfg_b_max_i,
  input  logic [StallWidth-1:0] cfg_r_max_i,
  input  req_t                  slv_req_i,
  output resp_t                 slv_resp_o,
  output req_t                  mst_req_o,
  input  resp_t                 mst_resp_i,
  output logic                  b_stalling_o,
  output logic                  r_stalling_o
`ifdef AXI_RESP_STALL_INJ_STATS_EN
  ,
  output logic [31:0]           b_stall_cycles_o,
  output logic [31:0]           r_stall_cycles_o
`endif
);

  localparam logic [1:0] PASS  = 2'd0;
  localparam logic [1:0] STALL = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;
  localparam int unsigned ChanW = StallWidth + 2;
  localparam logic [StallWidth:0] ModOne = (StallWidth+1)'(1);

  logic [1:0]            r_bState, r_rState;
  logic [StallWidth-1:0] r_bCnt, r_rCnt;
  logic [15:0]           r_lfsr;
  logic [15:0]           w_lfsrNext;
  logic                  w_bStall, w_rStall, w_bHs, w_rHs;
  logic [StallWidth-1:0] w_bDraw, w_rDraw;
  logic [ChanW-1:0]      w_bNext, w_rNext;

  function automatic logic [15:0] lfsrStep(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  // Remainder is formed one bit wider so an all-ones maximum cannot overflow max+1.
  function automatic logic [StallWidth-1:0] drawStall(input logic [StallWidth-1:0] rnd,
                                                      input logic [StallWidth-1:0] maxV);
    logic [StallWidth:0] rem;
    rem = {1'b0, rnd} % ({1'b0, maxV} + ModOne);
    return rem[StallWidth-1:0];
  endfunction

  function automatic logic [ChanW-1:0] nextChan(input logic [1:0]            st,
                                                input logic [StallWidth-1:0] cnt,
                                                input logic                  dnValid,
                                                input logic                  upReady,
                                                input logic                  hs,
                                                input logic                  en,
                                                input logic [StallWidth-1:0] draw);
    logic [1:0]            nSt;
    logic [StallWidth-1:0] nCnt;
    nSt  = st;
    nCnt = cnt;
    if (st == STALL) begin
      if (cnt <= StallWidth'(1)) begin
        nSt  = PASS;
        nCnt = '0;
      end else begin
        nCnt = cnt - StallWidth'(1);
      end
    end else if (hs) begin
      if (en && (draw != '0)) begin
        nSt  = STALL;
        nCnt = draw;
      end else begin
        nSt  = PASS;
        nCnt = '0;
      end
    end else if (st == PASS) begin
      if (dnValid && !upReady) nSt = HOLD;
    end else if (!dnValid) begin
      nSt = PASS;
    end
    return {nSt, nCnt};
  endfunction

  assign w_bStall     = (r_bState == STALL);
  assign w_rStall     = (r_rState == STALL);
  assign b_stalling_o = w_bStall;
  assign r_stalling_o = w_rStall;

  assign w_bHs = mst_resp_i.b_valid & slv_req_i.b_ready & ~w_bStall;
  assign w_rHs = mst_resp_i.r_valid & slv_req_i.r_ready & ~w_rStall;

  always_comb begin
    mst_req_o          = slv_req_i;
    mst_req_o.b_ready  = slv_req_i.b_ready & ~w_bStall;
    mst_req_o.r_ready  = slv_req_i.r_ready & ~w_rStall;
    slv_resp_o         = mst_resp_i;
    slv_resp_o.b_valid = mst_resp_i.b_valid & ~w_bStall;
    slv_resp_o.r_valid = mst_resp_i.r_valid & ~w_rStall;
  end

  // When both channels draw together, B takes the current LFSR value and R the next one.
  assign w_bDraw = drawStall(StallWidth'(r_lfsr), cfg_b_max_i);
  assign w_rDraw = drawStall(StallWidth'(w_bHs ? lfsrStep(r_lfsr) : r_lfsr), cfg_r_max_i);

  always_comb begin
    w_lfsrNext = r_lfsr;
    if (w_bHs && w_rHs)      w_lfsrNext = lfsrStep(lfsrStep(r_lfsr));
    else if (w_bHs || w_rHs) w_lfsrNext = lfsrStep(r_lfsr);
  end

  assign w_bNext = nextChan(r_bState, r_bCnt, mst_resp_i.b_valid, slv_req_i.b_ready,
                            w_bHs, cfg_en_i, w_bDraw);
  assign w_rNext = nextChan(r_rState, r_rCnt, mst_resp_i.r_valid, slv_req_i.r_ready,
                            w_rHs, cfg_en_i, w_rDraw);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_bState <= (InitialBStall != '0) ? STALL : PASS;
      r_rState <= (InitialRStall != '0) ? STALL : PASS;
      r_bCnt   <= InitialBStall;
      r_rCnt   <= InitialRStall;
      r_lfsr   <= LfsrSeed;
    end else begin
      {r_bState, r_bCnt} <= w_bNext;
      {r_rState, r_rCnt} <= w_rNext;
      r_lfsr             <= w_lfsrNext;
    end
  end

`ifdef AXI_RESP_STALL_INJ_STATS_EN
  logic [31:0] r_bStallCycles, r_rStallCycles;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_bStallCycles <= '0;
      r_rStallCycles <= '0;
    end else begin
      if (w_bStall && (r_bStallCycles != '1)) r_bStallCycles <= r_bStallCycles + 32'd1;
      if (w_rStall && (r_rStallCycles != '1)) r_rStallCycles <= r_rStallCycles + 32'd1;
    end
  end

  assign b_stall_cycles_o = r_bStallCycles;
  assign r_stall_cycles_o = r_rStallCycles;
`endif

endmodule

// File: tb/tb_axi_resp_stall_injector.sv
// Directed bench for axi_resp_stall_injector: an event-level stall model checked every cycle,
// plus hand-computed stall lengths derived from the LFSR seed 16'hACE1.

module tb_axi_resp_stall_injector;
  import axi_resp_stall_injector_pkg::*;

  localparam int InitB = 5;
  localparam int InitR = 3;
  localparam logic [15:0] Seed = 16'hACE1;

  logic      clk = 1'b0;
  logic      rst = 1'b0;
  logic      cfgEn = 1'b0;
  logic [7:0] cfgBMax = '0;
  logic [7:0] cfgRMax = '0;
  axi_req_t  slvReq = '0;
  axi_req_t  mstReq;
  axi_resp_t slvResp;
  axi_resp_t mstResp = '0;
  logic      bStalling, rStalling;
`ifdef AXI_RESP_STALL_INJ_STATS_EN
  logic [31:0] bStallCycles, rStallCycles;
`endif

  int nCompared = 0;
  int nMismatched = 0;

  // Event-level model: remaining stall cycles per channel and the shared random stream.
  bit          modelValid = 1'b0;
  int          bRemain = 0, rRemain = 0;
  int          bCyc = 0, rCyc = 0;
  logic [15:0] mLfsr = Seed;

  always #5 clk = ~clk;

  axi_resp_stall_injector #(
    .req_t(axi_req_t),
    .resp_t(axi_resp_t),
    .StallWidth(8),
    .InitialBStall(8'd5),
    .InitialRStall(8'd3),
    .LfsrSeed(Seed)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .cfg_en_i(cfgEn),
    .cfg_b_max_i(cfgBMax),
    .cfg_r_max_i(cfgRMax),
    .slv_req_i(slvReq),
    .slv_resp_o(slvResp),
    .mst_req_o(mstReq),
    .mst_resp_i(mstResp),
    .b_stalling_o(bStalling),
    .r_stalling_o(rStalling)
`ifdef AXI_RESP_STALL_INJ_STATS_EN
    ,
    .b_stall_cycles_o(bStallCycles),
    .r_stall_cycles_o(rStallCycles)
`endif
  );

  function automatic logic [15:0] lfsrNext(input logic [15:0] v);
    return {v[14:0], ^(v & 16'hB400)};
  endfunction

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic resetDut();
    slvReq  = '0;
    mstResp = '0;
    rst     = 1'b1;
    tick();
    rst     = 1'b0;
  endtask

  task automatic countStalls(input int window, output int nb, output int nr);
    nb = 0;
    nr = 0;
    for (int k = 0; k < window; k++) begin
      @(negedge clk);
      if (bStalling) nb++;
      if (rStalling) nr++;
      tick();
    end
  endtask

  // Random traffic on every channel; downstream responses stay valid until accepted.
  task automatic applyStimulus();
    slvReq.aw_valid = 1'($urandom);
    slvReq.aw.addr  = 32'($urandom);
    slvReq.aw.id    = 4'($urandom);
    slvReq.w_valid  = 1'($urandom);
    slvReq.w.data   = {$urandom, $urandom};
    slvReq.w.strb   = 8'($urandom);
    slvReq.ar_valid = 1'($urandom);
    slvReq.ar.addr  = 32'($urandom);
    slvReq.ar.len   = 8'($urandom);
    slvReq.b_ready  = ($urandom_range(0, 3) != 0);
    slvReq.r_ready  = ($urandom_range(0, 3) != 0);
    mstResp.aw_ready = 1'($urandom);
    mstResp.w_ready  = 1'($urandom);
    mstResp.ar_ready = 1'($urandom);
    if (!mstResp.b_valid) begin
      mstResp.b_valid = 1'($urandom);
      mstResp.b.id    = 4'($urandom);
      mstResp.b.resp  = 2'($urandom);
    end
    if (!mstResp.r_valid) begin
      mstResp.r_valid = 1'($urandom);
      mstResp.r.data  = {$urandom, $urandom};
      mstResp.r.last  = 1'($urandom);
    end
  endtask

  // Model advance: stalls count down; an accepted beat draws the next stall, B before R.
  initial forever begin
    bit bHs, rHs;
    @(posedge clk);
    if (rst) begin
      bRemain = InitB;
      rRemain = InitR;
      mLfsr   = Seed;
      bCyc    = 0;
      rCyc    = 0;
      modelValid = 1'b1;
    end else if (modelValid) begin
      bHs = mstResp.b_valid && slvReq.b_ready && (bRemain == 0);
      rHs = mstResp.r_valid && slvReq.r_ready && (rRemain == 0);
      if (bRemain > 0) begin bCyc++; bRemain--; end
      if (rRemain > 0) begin rCyc++; rRemain--; end
      if (bHs) begin
        if (cfgEn) bRemain = int'(mLfsr[7:0]) % (int'(cfgBMax) + 1);
        mLfsr = lfsrNext(mLfsr);
      end
      if (rHs) begin
        if (cfgEn) rRemain = int'(mLfsr[7:0]) % (int'(cfgRMax) + 1);
        mLfsr = lfsrNext(mLfsr);
      end
    end
  end

  initial forever begin
    axi_resp_t expResp;
    axi_req_t  expReq;
    @(negedge clk);
    if (modelValid) begin
      expResp = mstResp;
      expResp.b_valid = mstResp.b_valid && (bRemain == 0);
      expResp.r_valid = mstResp.r_valid && (rRemain == 0);
      expReq = slvReq;
      expReq.b_ready = slvReq.b_ready && (bRemain == 0);
      expReq.r_ready = slvReq.r_ready && (rRemain == 0);
      checkOutput("b_stalling", 256'(bStalling), 256'(bRemain > 0));
      checkOutput("r_stalling", 256'(rStalling), 256'(rRemain > 0));
      checkOutput("slv_resp", 256'(slvResp), 256'(expResp));
      checkOutput("mst_req", 256'(mstReq), 256'(expReq));
`ifdef AXI_RESP_STALL_INJ_STATS_EN
      checkOutput("b_stall_cycles", 256'(bStallCycles), 256'(bCyc));
      checkOutput("r_stall_cycles", 256'(rStallCycles), 256'(rCyc));
`endif
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int nb, nr, beats, cycles, stallSeen;
    checkOutput("lfsr_model_step1", 256'(lfsrNext(Seed)), 256'(16'h59C3));
    checkOutput("lfsr_model_step2", 256'(lfsrNext(lfsrNext(Seed))), 256'(16'hB387));

    // Reset-time stalls only.
    resetDut();
    cfgEn = 1'b0;
    slvReq.b_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (c == 1) begin
        mstResp.b_valid = 1'b1;
        mstResp.b.id    = 4'h5;
      end
      @(negedge clk);
      checkOutput("init_b_valid", 256'(slvResp.b_valid), 256'(c >= 5));
      checkOutput("init_r_stalling", 256'(rStalling), 256'(c < 3));
      tick();
    end
    mstResp.b_valid = 1'b0;
    countStalls(4, nb, nr);
    checkOutput("init_after_b_stalls", 256'(nb), 256'(0));

    // Zero maximum on R: an 8-beat burst flows without bubbles.
    resetDut();
    cfgEn = 1'b1;
    cfgBMax = 8'd0;
    cfgRMax = 8'd0;
    slvReq.r_ready = 1'b1;
    tick(); tick(); tick();
    beats = 0; cycles = 0; stallSeen = 0;
    while (beats < 8 && cycles < 20) begin
      mstResp.r_valid = 1'b1;
      mstResp.r.data  = {32'hBEEF0000 + 32'(beats), 32'(beats)};
      mstResp.r.last  = (beats == 7);
      @(negedge clk);
      if (rStalling) stallSeen++;
      if (mstReq.r_ready && mstResp.r_valid) beats++;
      cycles++;
      tick();
    end
    mstResp.r_valid = 1'b0;
    checkOutput("burst_cycles", 256'(cycles), 256'(8));
    checkOutput("burst_stalls", 256'(stallSeen), 256'(0));

    // Upstream back-pressure holds B valid; the next stall is 0xE1 mod 16 = 1.
    resetDut();
    cfgEn = 1'b1;
    cfgBMax = 8'd15;
    cfgRMax = 8'd0;
    mstResp.b_valid = 1'b1;
    mstResp.b.id    = 4'h3;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      checkOutput("hold_b_valid", 256'(slvResp.b_valid), 256'(c >= 5));
      tick();
    end
    slvReq.b_ready = 1'b1;
    tick();
    mstResp.b_valid = 1'b0;
    countStalls(6, nb, nr);
    checkOutput("hold_next_b_stall", 256'(nb), 256'(1));

    // Same-cycle B and R draws: B gets 0xE1=225, R gets 0xC3=195, then B gets 0x87=135.
    resetDut();
    cfgEn = 1'b1;
    cfgBMax = 8'd255;
    cfgRMax = 8'd255;
    slvReq.b_ready = 1'b1;
    slvReq.r_ready = 1'b1;
    for (int c = 0; c < 5; c++) tick();
    mstResp.b_valid = 1'b1;
    mstResp.r_valid = 1'b1;
    @(negedge clk);
    checkOutput("dual_b_valid", 256'(slvResp.b_valid), 256'(1));
    checkOutput("dual_r_valid", 256'(slvResp.r_valid), 256'(1));
    tick();
    mstResp.b_valid = 1'b0;
    mstResp.r_valid = 1'b0;
    countStalls(300, nb, nr);
    checkOutput("dual_b_stall", 256'(nb), 256'(225));
    checkOutput("dual_r_stall", 256'(nr), 256'(195));
    mstResp.b_valid = 1'b1;
    tick();
    mstResp.b_valid = 1'b0;
    countStalls(200, nb, nr);
    checkOutput("after_dual_b_stall", 256'(nb), 256'(135));

    // Reset during a 4-cycle R stall (225 mod 13 = 4) restores initial stall and seed.
    resetDut();
    cfgEn = 1'b1;
    cfgBMax = 8'd0;
    cfgRMax = 8'd12;
    slvReq.r_ready = 1'b1;
    tick(); tick(); tick();
    mstResp.r_valid = 1'b1;
    mstResp.r.data  = 64'h0123_4567_89AB_CDEF;
    tick();
    @(negedge clk);
    checkOutput("pre_reset_r_stalling", 256'(rStalling), 256'(1));
    tick();
    rst = 1'b1;
    mstResp.r_valid = 1'b0;
    tick();
    rst = 1'b0;
    mstResp.r_valid = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checkOutput("post_reset_r_stalling", 256'(rStalling), 256'(c < 3));
      checkOutput("post_reset_r_valid", 256'(slvResp.r_valid), 256'(c >= 3));
      tick();
    end
    mstResp.r_valid = 1'b0;
    countStalls(8, nb, nr);
    checkOutput("post_reset_r_draw", 256'(nr), 256'(4));

    // Random traffic with small maxima; the configured maximum changes mid-run.
    resetDut();
    cfgEn = 1'b1;
    cfgBMax = 8'd7;
    cfgRMax = 8'd7;
    for (int c = 0; c < 400; c++) begin
      bit bDone, rDone;
      if (c == 200) cfgBMax = 8'd3;
      if (c == 300) cfgEn = 1'b0;
      applyStimulus();
      @(negedge clk);
      bDone = mstResp.b_valid && mstReq.b_ready;
      rDone = mstResp.r_valid && mstReq.r_ready;
      tick();
      if (bDone) mstResp.b_valid = 1'b0;
      if (rDone) mstResp.r_valid = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
